key_entry_fsm: RTL and testbench

KEY_ENTRY_FSM -- requirements
Module: key_entry_fsm

---
 rtl/key_entry_fsm.sv | 107 ++++++++++
 tb/tb_key_entry_fsm.sv | 129 ++++++++++++
 2 files changed

// File: rtl/key_entry_fsm.sv
// key_entry_fsm: debounces a held keypad code and edits a 4-digit BCD entry with backspace/enter/clear.
module key_entry_fsm #(
   parameter int unsigned STABLE_CYCLES = 2_000_000
) (
   input  logic        clk_100MHz,
   input  logic        rst_n,
   input  logic [3:0]  key_code,
   output logic [15:0] entry,
   output logic [2:0]  digit_count,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        key_err
);
   typedef enum logic [1:0] {ARM, IDLE, DEBOUNCE, COMMIT} state_t;
   localparam logic [21:0] LAST = 22'(STABLE_CYCLES - 1);
   state_t      state_q;
   logic [3:0]  last_key_q, cand_q;
   logic [21:0] cnt_q;
   logic [15:0] entry_q, value_q;
   logic [2:0]  count_q;
   logic        value_valid_q, key_err_q;
   assign entry       = entry_q;
   assign digit_count = count_q;
   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign key_err     = key_err_q;
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARM;
         last_key_q    <= 4'h0;
         cand_q        <= 4'h0;
         cnt_q         <= '0;
         entry_q       <= '0;
         value_q       <= '0;
         count_q       <= '0;
         value_valid_q <= 1'b0;
         key_err_q     <= 1'b0;
      end else begin
         value_valid_q <= 1'b0;
         key_err_q     <= 1'b0;
         case (state_q)
            // ARM only establishes a baseline key; it never acts on it
            ARM: begin
               if (key_code != cand_q) begin
                  cand_q <= key_code;
                  cnt_q  <= '0;
               end else if (cnt_q == LAST) begin
                  last_key_q <= cand_q;
                  state_q    <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 22'd1;
               end
            end
            IDLE: begin
               if (key_code != last_key_q) begin
                  cand_q  <= key_code;
                  cnt_q   <= '0;
                  state_q <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (key_code == cand_q) begin
                  cnt_q <= cnt_q + 22'd1;
                  if (cnt_q == LAST) state_q <= COMMIT;
               end else if (key_code == last_key_q) begin
                  state_q <= IDLE;
               end else begin
                  cand_q <= key_code;
                  cnt_q  <= '0;
               end
            end
            COMMIT: begin
               last_key_q <= cand_q;
               state_q    <= IDLE;
               if (cand_q <= 4'd9) begin
                  if (count_q < 3'd4) begin
                     entry_q <= {entry_q[11:0], cand_q};
                     count_q <= count_q + 3'd1;
                  end else begin
                     key_err_q <= 1'b1;
                  end
               end else if (cand_q == 4'hD) begin
                  if (count_q != 3'd0) begin
                     entry_q <= {4'h0, entry_q[15:4]};
                     count_q <= count_q - 3'd1;
                  end
               end else if (cand_q == 4'hE) begin
                  if (count_q != 3'd0) begin
                     value_q       <= entry_q;
                     value_valid_q <= 1'b1;
                     entry_q       <= '0;
                     count_q       <= '0;
                  end else begin
                     key_err_q <= 1'b1;
                  end
               end else if (cand_q == 4'hF) begin
                  entry_q <= '0;
                  count_q <= '0;
               end else begin
                  key_err_q <= 1'b1;
               end
            end
            default: state_q <= ARM;
         endcase
      end
   end
endmodule

// File: tb/tb_key_entry_fsm.sv
// tb_key_entry_fsm: directed checks of debounce, digit editing, enter latency and reset abort.
module tb_key_entry_fsm;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  key_code;
   logic [15:0] entry, value;
   logic [2:0]  digit_count;
   logic        value_valid, key_err;
   int          checks = 0, failures = 0, vv_n = 0, err_n = 0;

   key_entry_fsm #(.STABLE_CYCLES(4)) dut (
      .clk_100MHz(clk), .rst_n(rst_n), .key_code(key_code), .entry(entry),
      .digit_count(digit_count), .value(value), .value_valid(value_valid), .key_err(key_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (value_valid === 1'b1) vv_n++;
      if (key_err === 1'b1) err_n++;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic [3:0] k, input int n);
      key_code = k;
      repeat (n) @(negedge clk);
   endtask

   task automatic outs(input string tag, input logic [15:0] e, input logic [2:0] c);
      check({tag, "_entry"}, entry, e);
      check({tag, "_count"}, {13'd0, digit_count}, {13'd0, c});
   endtask

   initial begin
      rst_n = 1'b0;
      key_code = 4'hF;
      repeat (3) @(negedge clk);
      outs("reset", 16'h0000, 3'd0);
      check("reset_value", value, 16'h0000);
      check("reset_pulses", {14'd0, value_valid, key_err}, 16'h0000);
      rst_n = 1'b1;
      hold(4'hF, 8);
      outs("powerup_f", 16'h0000, 3'd0);
      hold(4'h1, 8);
      hold(4'h2, 8);
      hold(4'h3, 8);
      outs("digits_123", 16'h0123, 3'd3);
      check("digits_123_err", 16'(err_n), 16'd0);
      hold(4'hF, 8);
      outs("clear", 16'h0000, 3'd0);
      hold(4'h9, 8);
      hold(4'h8, 8);
      hold(4'h7, 8);
      hold(4'h6, 8);
      outs("full_9876", 16'h9876, 3'd4);
      hold(4'h5, 8);
      outs("overflow", 16'h9876, 3'd4);
      check("overflow_err", 16'(err_n), 16'd1);
      hold(4'h5, 16);
      check("repeat_no_action", 16'(err_n), 16'd1);
      hold(4'hF, 8);
      hold(4'h4, 8);
      hold(4'h2, 8);
      outs("entry_42", 16'h0042, 3'd2);
      key_code = 4'hE;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) begin
            check("enter_e5_vv", {15'd0, value_valid}, 16'd0);
            check("enter_e5_value", value, 16'h0000);
         end
         if (k == 6) begin
            check("enter_e6_vv", {15'd0, value_valid}, 16'd1);
            check("enter_e6_value", value, 16'h0042);
            outs("enter_e6", 16'h0000, 3'd0);
         end
         if (k == 7) check("enter_e7_vv", {15'd0, value_valid}, 16'd0);
      end
      hold(4'hE, 4);
      check("enter_vv_count", 16'(vv_n), 16'd1);
      hold(4'h3, 8);
      hold(4'h7, 2);
      hold(4'h3, 10);
      outs("glitch", 16'h0003, 3'd1);
      check("glitch_err", 16'(err_n), 16'd1);
      hold(4'hF, 8);
      hold(4'h1, 8);
      hold(4'h2, 8);
      hold(4'hD, 8);
      outs("bksp_1", 16'h0001, 3'd1);
      hold(4'h3, 8);
      hold(4'hD, 8);
      outs("bksp_2", 16'h0001, 3'd1);
      hold(4'hF, 8);
      hold(4'hD, 8);
      outs("bksp_empty", 16'h0000, 3'd0);
      check("bksp_empty_err", 16'(err_n), 16'd1);
      hold(4'hE, 8);
      check("enter_empty_err", 16'(err_n), 16'd2);
      check("enter_empty_value", value, 16'h0042);
      hold(4'hA, 8);
      check("key_a_err", 16'(err_n), 16'd3);
      hold(4'h7, 8);
      outs("pre_reset", 16'h0007, 3'd1);
      key_code = 4'h4;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      outs("mid_reset", 16'h0000, 3'd0);
      check("mid_reset_value", value, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold(4'h4, 16);
      outs("post_reset", 16'h0000, 3'd0);
      check("post_reset_pulses", 16'(vv_n + err_n), 16'd4);
      hold(4'h5, 8);
      outs("post_reset_digit", 16'h0005, 3'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
